// File: rtl/icache_refill_ctrl.sv
// Instruction cache miss/refill sequencer: looks up the cache, refills misses from
// instruction memory over a req/ack handshake and keeps saturating hit/miss counts.
module icache_refill_ctrl #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cpu_req_i,
   input  logic [31:0]      cpu_pc_i,
   output logic             cpu_ready_o,
   output logic             cpu_err_o,
   output logic             stall_o,
   output logic [31:0]      cache_pc_o,
   output logic             cache_we_o,
   output logic [31:0]      cache_inst_o,
   input  logic             hit_i,
   output logic             mem_req_o,
   output logic [31:0]      mem_addr_o,
   input  logic             mem_ack_i,
   input  logic [31:0]      mem_data_i,
   input  logic             mem_err_i,
   output logic [CNT_W-1:0] hit_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o
);

   typedef enum logic [1:0] {IDLE, LOOKUP, MEM_WAIT, FILL} state_t;

   localparam logic [15:0]      TMO_LIMIT = 16'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t      state, state_next;
   logic [31:0] pc_q;
   logic [31:0] data_q;
   logic        refilled;
   logic [15:0] tmo_cnt;
   logic        first_hit;
   logic        first_miss;

   assign first_hit  = (state == LOOKUP) && hit_i && !refilled;
   assign first_miss = (state == LOOKUP) && !hit_i && !refilled;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   // Only IDLE follows the live CPU inputs; everything after accept works from pc_q.
   always_comb begin
      state_next   = state;
      cpu_ready_o  = 1'b0;
      cpu_err_o    = 1'b0;
      stall_o      = 1'b1;
      cache_pc_o   = pc_q;
      cache_we_o   = 1'b0;
      cache_inst_o = 32'h0;
      mem_req_o    = 1'b0;
      mem_addr_o   = 32'h0;
      case (state)
         IDLE: begin
            stall_o    = cpu_req_i && !rst_i;
            cache_pc_o = cpu_pc_i;
            if (cpu_req_i) state_next = LOOKUP;
         end
         LOOKUP: begin
            if (hit_i) begin
               cpu_ready_o = 1'b1;
               stall_o     = 1'b0;
               state_next  = IDLE;
            end else if (refilled) begin
               cpu_err_o  = 1'b1;
               stall_o    = 1'b0;
               state_next = IDLE;
            end else begin
               state_next = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            mem_req_o  = 1'b1;
            mem_addr_o = {pc_q[31:2], 2'b00};
            if (mem_ack_i) begin
               state_next = FILL;
            end else if (mem_err_i || (tmo_cnt == TMO_LIMIT)) begin
               cpu_err_o  = 1'b1;
               stall_o    = 1'b0;
               state_next = IDLE;
            end
         end
         FILL: begin
            cache_we_o   = 1'b1;
            cache_inst_o = data_q;
            state_next   = LOOKUP;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q     <= 32'h0;
         data_q   <= 32'h0;
         refilled <= 1'b0;
         tmo_cnt  <= 16'h0;
      end else begin
         if (state == IDLE && cpu_req_i) begin
            pc_q     <= cpu_pc_i;
            refilled <= 1'b0;
         end
         if (state == FILL) refilled <= 1'b1;
         if (state == MEM_WAIT && mem_ack_i) data_q <= mem_data_i;
         // Counter is held at zero outside MEM_WAIT, so it restarts on every entry.
         if (state == MEM_WAIT) tmo_cnt <= tmo_cnt + 16'd1;
         else                   tmo_cnt <= 16'h0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (first_hit && hit_cnt_o != CNT_MAX)   hit_cnt_o  <= hit_cnt_o + CNT_W'(1);
         if (first_miss && miss_cnt_o != CNT_MAX) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a small direct-mapped cache model supplies
// hit_i, memory responses are driven by hand, and every step checks hand-computed values.
module tb_icache_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [31:0] cpu_pc;
   logic        cpu_ready;
   logic        cpu_err;
   logic        stall;
   logic [31:0] cache_pc;
   logic        cache_we;
   logic [31:0] cache_inst;
   logic        hit;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_data;
   logic        mem_err;
   logic [1:0]  hit_cnt;
   logic [1:0]  miss_cnt;
   logic        force_miss;

   int checks;
   int errors;

   logic        model_valid [0:255];
   logic [21:0] model_tag   [0:255];
   logic [31:0] model_pc;

   icache_refill_ctrl #(.CNT_W(2), .TIMEOUT(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .cpu_req_i(cpu_req), .cpu_pc_i(cpu_pc),
      .cpu_ready_o(cpu_ready), .cpu_err_o(cpu_err), .stall_o(stall),
      .cache_pc_o(cache_pc), .cache_we_o(cache_we), .cache_inst_o(cache_inst),
      .hit_i(hit),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr),
      .mem_ack_i(mem_ack), .mem_data_i(mem_data), .mem_err_i(mem_err),
      .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
   );

   always #5 clk = ~clk;

   // Cache model registers the index every edge; reset preloads index 0 (tag 0) and 0x10 (tag 0).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) begin
            model_valid[i] <= 1'b0;
            model_tag[i]   <= 22'h0;
         end
         model_valid[0]     <= 1'b1;
         model_valid[8'h10] <= 1'b1;
         model_pc           <= 32'h0;
      end else begin
         model_pc <= cache_pc;
         if (cache_we) begin
            model_valid[cache_pc[9:2]] <= 1'b1;
            model_tag[cache_pc[9:2]]   <= cache_pc[31:10];
         end
      end
   end

   assign hit = model_valid[model_pc[9:2]] && (model_tag[model_pc[9:2]] == model_pc[31:10]) && !force_miss;

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic req, input logic [31:0] pc);
      cpu_req = req;
      cpu_pc  = pc;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0; force_miss = 1'b0;
      applyStimulus(1'b0, 32'h0);
      mem_ack = 1'b0; mem_data = 32'h0; mem_err = 1'b0;
      #1 rst = 1'b1;
      nextCycle; nextCycle;
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_ready", 32'(cpu_ready), 32'd0);
      checkOutput("rst_stall", 32'(stall), 32'd0);
      checkOutput("rst_we", 32'(cache_we), 32'd0);
      checkOutput("rst_hit_cnt", 32'(hit_cnt), 32'd0);
      checkOutput("rst_miss_cnt", 32'(miss_cnt), 32'd0);
      rst = 1'b0;
      nextCycle;

      $display("[TB] hit at 0x40");
      applyStimulus(1'b1, 32'h40);
      #1 checkOutput("idle_stall", 32'(stall), 32'd1);
      nextCycle;
      checkOutput("hit_ready", 32'(cpu_ready), 32'd1);
      checkOutput("hit_stall", 32'(stall), 32'd0);
      checkOutput("hit_mem_req", 32'(mem_req), 32'd0);
      checkOutput("hit_cache_pc", cache_pc, 32'h40);
      applyStimulus(1'b0, 32'h40);
      nextCycle;
      checkOutput("hit_ready_pulse", 32'(cpu_ready), 32'd0);
      checkOutput("hit_cnt1", 32'(hit_cnt), 32'd1);
      checkOutput("hit_miss_cnt0", 32'(miss_cnt), 32'd0);
      mem_ack = 1'b1; mem_data = 32'h0BAD_0BAD;
      nextCycle;
      mem_ack = 1'b0;
      checkOutput("stray_ack_req", 32'(mem_req), 32'd0);
      checkOutput("stray_ack_we", 32'(cache_we), 32'd0);

      $display("[TB] miss/refill at 0x400");
      applyStimulus(1'b1, 32'h400);
      nextCycle;
      checkOutput("miss_lookup_ready", 32'(cpu_ready), 32'd0);
      checkOutput("miss_lookup_req", 32'(mem_req), 32'd0);
      checkOutput("miss_lookup_stall", 32'(stall), 32'd1);
      nextCycle;
      checkOutput("miss_mem_req", 32'(mem_req), 32'd1);
      checkOutput("miss_mem_addr", mem_addr, 32'h400);
      checkOutput("miss_cnt1", 32'(miss_cnt), 32'd1);
      applyStimulus(1'b1, 32'hFFF0);
      nextCycle;
      checkOutput("pc_toggle_addr", mem_addr, 32'h400);
      checkOutput("pc_toggle_cache_pc", cache_pc, 32'h400);
      nextCycle;
      mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
      #1 checkOutput("ack_cycle_req", 32'(mem_req), 32'd1);
      nextCycle;
      mem_ack = 1'b0; mem_data = 32'h0;
      checkOutput("fill_we", 32'(cache_we), 32'd1);
      checkOutput("fill_inst", cache_inst, 32'hDEAD_BEEF);
      checkOutput("fill_cache_pc", cache_pc, 32'h400);
      checkOutput("fill_mem_req", 32'(mem_req), 32'd0);
      checkOutput("fill_mem_addr", mem_addr, 32'h0);
      nextCycle;
      checkOutput("miss_ready", 32'(cpu_ready), 32'd1);
      checkOutput("miss_we_once", 32'(cache_we), 32'd0);
      applyStimulus(1'b0, 32'h400);
      nextCycle;
      checkOutput("miss_hit_cnt", 32'(hit_cnt), 32'd1);
      checkOutput("miss_cnt_after", 32'(miss_cnt), 32'd1);

      $display("[TB] ack and error together at 0x800");
      applyStimulus(1'b1, 32'h800);
      nextCycle; nextCycle;
      mem_ack = 1'b1; mem_err = 1'b1; mem_data = 32'h1234_5678;
      #1 checkOutput("ackerr_err", 32'(cpu_err), 32'd0);
      nextCycle;
      mem_ack = 1'b0; mem_err = 1'b0;
      checkOutput("ackerr_we", 32'(cache_we), 32'd1);
      checkOutput("ackerr_inst", cache_inst, 32'h1234_5678);
      nextCycle;
      checkOutput("ackerr_ready", 32'(cpu_ready), 32'd1);
      applyStimulus(1'b0, 32'h800);
      nextCycle;
      checkOutput("miss_cnt2", 32'(miss_cnt), 32'd2);

      $display("[TB] memory error at 0x400");
      applyStimulus(1'b1, 32'h400);
      nextCycle; nextCycle;
      mem_err = 1'b1;
      #1 checkOutput("err_pulse", 32'(cpu_err), 32'd1);
      checkOutput("err_stall", 32'(stall), 32'd0);
      checkOutput("err_we", 32'(cache_we), 32'd0);
      applyStimulus(1'b0, 32'h400);
      nextCycle;
      mem_err = 1'b0;
      checkOutput("err_pulse_end", 32'(cpu_err), 32'd0);
      checkOutput("err_no_we", 32'(cache_we), 32'd0);
      checkOutput("err_req_drop", 32'(mem_req), 32'd0);
      checkOutput("miss_cnt3", 32'(miss_cnt), 32'd3);

      $display("[TB] timeout at 0xC00");
      applyStimulus(1'b1, 32'hC00);
      nextCycle;
      checkOutput("tmo_lookup_req", 32'(mem_req), 32'd0);
      nextCycle;
      checkOutput("tmo_req_rise", 32'(mem_req), 32'd1);
      checkOutput("tmo_err0", 32'(cpu_err), 32'd0);
      checkOutput("miss_sat4", 32'(miss_cnt), 32'd3);
      for (int i = 1; i <= 3; i++) begin
         nextCycle;
         checkOutput("tmo_wait_err", 32'(cpu_err), 32'd0);
         checkOutput("tmo_wait_req", 32'(mem_req), 32'd1);
      end
      nextCycle;
      checkOutput("tmo_err", 32'(cpu_err), 32'd1);
      applyStimulus(1'b0, 32'hC00);
      nextCycle;
      checkOutput("tmo_req_drop", 32'(mem_req), 32'd0);
      checkOutput("tmo_err_end", 32'(cpu_err), 32'd0);

      $display("[TB] post-fill miss at 0x1000");
      applyStimulus(1'b1, 32'h1000);
      nextCycle; nextCycle;
      mem_ack = 1'b1; mem_data = 32'hA5A5_5A5A;
      nextCycle;
      mem_ack = 1'b0; force_miss = 1'b1;
      checkOutput("pf_we", 32'(cache_we), 32'd1);
      nextCycle;
      checkOutput("pf_err", 32'(cpu_err), 32'd1);
      checkOutput("pf_ready", 32'(cpu_ready), 32'd0);
      applyStimulus(1'b0, 32'h1000);
      force_miss = 1'b0;
      nextCycle;
      checkOutput("pf_idle_req", 32'(mem_req), 32'd0);
      checkOutput("miss_sat5", 32'(miss_cnt), 32'd3);
      checkOutput("pf_hit_cnt", 32'(hit_cnt), 32'd1);

      $display("[TB] reset during MEM_WAIT");
      applyStimulus(1'b1, 32'h2000);
      nextCycle; nextCycle;
      checkOutput("prerst_req", 32'(mem_req), 32'd1);
      rst = 1'b1;
      #1 checkOutput("midrst_req", 32'(mem_req), 32'd0);
      checkOutput("midrst_stall", 32'(stall), 32'd0);
      checkOutput("midrst_hit_cnt", 32'(hit_cnt), 32'd0);
      checkOutput("midrst_miss_cnt", 32'(miss_cnt), 32'd0);
      applyStimulus(1'b0, 32'h2000);
      nextCycle;
      rst = 1'b0;
      nextCycle;
      applyStimulus(1'b1, 32'h100);
      nextCycle;
      checkOutput("post_rst_lookup", 32'(cpu_ready), 32'd0);
      nextCycle;
      checkOutput("post_rst_req", 32'(mem_req), 32'd1);
      checkOutput("post_rst_addr", mem_addr, 32'h100);
      checkOutput("post_rst_miss_cnt", 32'(miss_cnt), 32'd1);
      mem_ack = 1'b1; mem_data = 32'hCAFE_F00D;
      nextCycle;
      mem_ack = 1'b0;
      checkOutput("post_rst_we", 32'(cache_we), 32'd1);
      checkOutput("post_rst_inst", cache_inst, 32'hCAFE_F00D);
      checkOutput("post_rst_cache_pc", cache_pc, 32'h100);
      nextCycle;
      checkOutput("post_rst_ready", 32'(cpu_ready), 32'd1);
      checkOutput("post_rst_hit_cnt", 32'(hit_cnt), 32'd0);
      applyStimulus(1'b0, 32'h100);
      nextCycle;
      checkOutput("post_rst_stall", 32'(stall), 32'd0);
      checkOutput("post_rst_miss_end", 32'(miss_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
